stream_buf: RTL and testbench

- Two-entry valid/ready register slice (skid buffer) for a unidirectional data stream.
- Decouples upstream and downstream timing: every output, including o_ready, comes straight from a flop, and there is no combinational path from input to output.
- Sustains one transfer per clock. Instances can be chained back-to-back in pipelines.

---
 rtl/stream_buf.sv | 76 +++++++
 tb/tb_stream_buf.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/stream_buf.sv
// stream_buf: two-entry valid/ready skid buffer; every output is driven by a flop.
// Define STREAM_BUF_LEVEL_EN to add the registered o_level occupancy output.
module stream_buf #(
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_valid,
   output logic              o_ready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready
`ifdef STREAM_BUF_LEVEL_EN
   ,
   output logic [1:0]        o_level
`endif
);
   logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
   logic              main_v_q, main_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d;
   logic              in_x, out_x;
   always_comb begin
      in_x     = i_valid && rdy_q;
      out_x    = main_v_q && i_ready;
      main_d   = main_q;
      main_v_d = main_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      if (skid_v_q) begin
         if (out_x) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
         end
      end else if (main_v_q) begin
         if (in_x && !out_x) begin
            skid_d   = i_data;
            skid_v_d = 1'b1;
         end else if (in_x) begin
            main_d = i_data;
         end else if (out_x) begin
            main_v_d = 1'b0;
         end
      end else if (in_x) begin
         main_d   = i_data;
         main_v_d = 1'b1;
      end
      // ready is re-registered from next skid state so it never passes through logic
      rdy_d = !skid_v_d;
   end
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         main_q   <= '0;
         main_v_q <= 1'b0;
         skid_q   <= '0;
         skid_v_q <= 1'b0;
         rdy_q    <= 1'b1;
      end else begin
         main_q   <= main_d;
         main_v_q <= main_v_d;
         skid_q   <= skid_d;
         skid_v_q <= skid_v_d;
         rdy_q    <= rdy_d;
      end
   end
   assign o_data  = main_q;
   assign o_valid = main_v_q;
   assign o_ready = rdy_q;
`ifdef STREAM_BUF_LEVEL_EN
   logic [1:0] level_q;
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) level_q <= 2'd0;
      else          level_q <= skid_v_d ? 2'd2 : {1'b0, main_v_d};
   end
   assign o_level = level_q;
`endif
endmodule

// File: tb/tb_stream_buf.sv
// tb_stream_buf: two chained buffers, queue scoreboard plus directed and random traffic.
module tb_stream_buf;
   logic       clk = 1'b0;
   logic       rst_n, src_valid, sink_ready;
   logic [7:0] src_data, d0, d1;
   logic       v0, v1, rdy0, rdy1;
`ifdef STREAM_BUF_LEVEL_EN
   logic [1:0] lv0, lv1;
`endif
   int         chks = 0, errs = 0, npop = 0, nsrc, base;
   logic [7:0] q[$];
   logic       pv = 1'b0;
   logic [7:0] pd = '0;
   bit         x;

   always #5 clk = ~clk;

   stream_buf #(.DATA_W(8)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(src_data), .i_valid(src_valid),
      .o_ready(rdy0), .o_data(d0), .o_valid(v0), .i_ready(rdy1)
`ifdef STREAM_BUF_LEVEL_EN
      , .o_level(lv0)
`endif
   );
   stream_buf #(.DATA_W(8)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(d0), .i_valid(v0),
      .o_ready(rdy1), .o_data(d1), .o_valid(v1), .i_ready(sink_ready)
`ifdef STREAM_BUF_LEVEL_EN
      , .o_level(lv1)
`endif
   );

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      chks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
      end
   endtask

   // x reports whether the source handshake completed on this edge
   task automatic step(output bit xf);
      xf = src_valid && rdy0 && rst_n;
      @(posedge clk);
      #1;
   endtask

   task automatic run_cnt(input int n);
      for (int i = 0; i < n; i++) begin
         step(x);
         if (x) begin
            nsrc++;
            src_data = src_data + 8'd1;
         end
      end
   endtask

   // Monitor: handshakes sampled mid-cycle, they take effect at the next rising edge
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         pv = 1'b0;
      end else begin
         if (pv) begin
            chk("stall_valid", v1, 1);
            chk("stall_data", d1, pd);
         end
         if (v1 && sink_ready) begin
            if (q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
               chk("order", d1, q.pop_front());
               npop++;
            end
         end
         if (src_valid && rdy0) q.push_back(src_data);
         pv = v1 && !sink_ready;
         pd = d1;
      end
   end

   initial begin
      rst_n = 1'b0; src_valid = 1'b0; src_data = '0; sink_ready = 1'b0; nsrc = 0;
      step(x);
      step(x);
      chk("rst_v0", v0, 0); chk("rst_v1", v1, 0);
      chk("rst_rdy0", rdy0, 1); chk("rst_rdy1", rdy1, 1);
      chk("rst_d0", d0, 0); chk("rst_d1", d1, 0);
      rst_n = 1'b1; src_valid = 1'b1;
      run_cnt(5);
      chk("fill_words", nsrc, 4); chk("fill_rdy0", rdy0, 0);
      chk("fill_v1", v1, 1); chk("fill_d1", d1, 0);
      base = npop; sink_ready = 1'b1;
      run_cnt(5);
      chk("flow_pops", npop - base, 5); chk("flow_src", nsrc, 7); chk("flow_d1", d1, 5);
      src_valid = 1'b0;
      for (int i = 0; i < 10 && v1; i++) step(x);
      chk("drain_v1", v1, 0); chk("drain_rdy0", rdy0, 1);
      chk("drain_rdy1", rdy1, 1); chk("drain_pops", npop, 7);
      src_valid = 1'b1; sink_ready = 1'b0;
      run_cnt(4);
      chk("full_rdy1", rdy1, 0); chk("full_d1", d1, 7);
      sink_ready = 1'b1;
      run_cnt(1);
      sink_ready = 1'b0;
      chk("unfull_rdy1", rdy1, 1); chk("unfull_v1", v1, 1); chk("unfull_d1", d1, 8);
      run_cnt(1);
      chk("refull_rdy1", rdy1, 0);
      rst_n = 1'b0; src_valid = 1'b0;
      step(x);
      chk("frst_v1", v1, 0); chk("frst_rdy1", rdy1, 1); chk("frst_d1", d1, 0);
      chk("frst_v0", v0, 0); chk("frst_rdy0", rdy0, 1);
      rst_n = 1'b1; src_valid = 1'b1; src_data = 8'hA5;
      step(x);
      src_valid = 1'b0;
      chk("post_rst_acc", x, 1); chk("post_rst_v0", v0, 1); chk("post_rst_d0", d0, 8'hA5);
      step(x);
      chk("post_rst_d1", d1, 8'hA5);
      sink_ready = 1'b1;
      for (int i = 0; i < 10 && v1; i++) step(x);
      chk("post_rst_drain", v1, 0);
      begin
         logic [1:0] lexp [5];
         lexp[0] = 0; lexp[1] = 1; lexp[2] = 2; lexp[3] = 1; lexp[4] = 0;
         sink_ready = 1'b0; src_valid = 1'b1; src_data = 8'h40;
         for (int i = 0; i < 5; i++) begin
            if (i == 3) sink_ready = 1'b1;
            step(x);
            if (x) src_data = src_data + 8'd1;
            if (i == 1) src_valid = 1'b0;
`ifdef STREAM_BUF_LEVEL_EN
            chk("level_seq", lv1, lexp[i]);
`endif
         end
         chk("level_seq_v1", v1, 0);
      end
      for (int i = 0; i < 3000; i++) begin
         rst_n      = ($urandom_range(0, 249) != 0);
         src_valid  = ($urandom_range(0, 3) != 0);
         sink_ready = ($urandom_range(0, 2) != 0);
         src_data   = 8'($urandom);
         step(x);
`ifdef STREAM_BUF_LEVEL_EN
         if (lv0 == 2'd3 || lv1 == 2'd3) chk("level_range", {lv0, lv1}, 0);
`endif
      end
      rst_n = 1'b1; src_valid = 1'b0; sink_ready = 1'b1;
      repeat (6) step(x);
      chk("final_empty", q.size(), 0); chk("final_v1", v1, 0);
      $display("CHECKS %0d ERRORS %0d", chks, errs);
      $finish;
   end
endmodule
